// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two write-back ports, optional write-to-read bypass
// and a per-register busy scoreboard for RAW hazard detection at decode.
module regfile_mp_sb #(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 5,
  parameter int                NUM_RD  = 2,
  parameter int                BYPASS  = 1,
  parameter int                GP_IDX  = 28,
  parameter logic [DATA_W-1:0] GP_INIT = 32'h0000_1800,
  parameter int                SP_IDX  = 29,
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_2ffc,
  localparam int               DEPTH   = 2**ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     w0_en,
  input  logic [ADDR_W-1:0]        w0_addr,
  input  logic [DATA_W-1:0]        w0_data,
  input  logic                     w1_en,
  input  logic [ADDR_W-1:0]        w1_addr,
  input  logic [DATA_W-1:0]        w1_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     sb_flush,
  output logic [DEPTH-1:0]         busy_vec
);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  busy_reg;
  logic [DEPTH-1:0]  busy_next;
  logic [DEPTH-1:0]  clr;

  // Entry 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == GP_IDX)
          mem_reg[i] <= GP_INIT;
        else if (i == SP_IDX)
          mem_reg[i] <= SP_INIT;
        else
          mem_reg[i] <= '0;
      end
      busy_reg <= '0;
    end else begin
      if (w0_en && w0_addr != '0)
        mem_reg[w0_addr] <= w0_data;
      // Later assignment gives the MEM port priority on an index collision.
      if (w1_en && w1_addr != '0)
        mem_reg[w1_addr] <= w1_data;
      busy_reg <= busy_next;
    end
  end

  always_comb begin
    clr       = '0;
    busy_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      clr[i] = (w0_en && w0_addr == ADDR_W'(i)) || (w1_en && w1_addr == ADDR_W'(i));
    end
    // Issue is OR-ed in last so a new producer outranks both flush and write-back.
    for (int i = 1; i < DEPTH; i++) begin
      busy_next[i] = ((sb_flush ? 1'b0 : (busy_reg[i] & ~clr[i]))
                      | (iss_en && iss_addr == ADDR_W'(i)));
    end
  end

  assign busy_vec = busy_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;

      assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        data = mem_reg[addr];
        if (BYPASS != 0 && w0_en && w0_addr == addr)
          data = w0_data;
        if (BYPASS != 0 && w1_en && w1_addr == addr)
          data = w1_data;
        if (addr == '0)
          data = '0;
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data;
      assign rd_busy[gi] = (addr != '0) && busy_reg[addr]
                           && ((BYPASS != 0) ? !clr[addr] : 1'b1);
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios plus randomized traffic
// compared against an array/bitmap reference model.
module tb_regfile_mp_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;
  localparam logic [31:0] GP_VAL = 32'h0000_1800;
  localparam logic [31:0] SP_VAL = 32'h0000_2ffc;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             w0_en, w1_en, iss_en, sb_flush;
  logic [AW-1:0]    w0_addr, w1_addr, iss_addr;
  logic [DW-1:0]    w0_data, w1_data;
  logic [DEPTH-1:0] busy_vec;

  int checks = 0;
  int errors = 0;

  // Reference model: plain register contents and a set of busy registers.
  logic [31:0] m_regs [DEPTH];
  bit          m_busy [DEPTH];

  regfile_mp_sb dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .sb_flush(sb_flush), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = 32'h0;
      m_busy[i] = 1'b0;
    end
    m_regs[28] = GP_VAL;
    m_regs[29] = SP_VAL;
  endfunction

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < DEPTH; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic bit written_now(int a);
    return (w0_en && int'(w0_addr) == a) || (w1_en && int'(w1_addr) == a);
  endfunction

  function automatic logic [31:0] exp_read(int a);
    if (a == 0) return 32'h0;
    if (w1_en && int'(w1_addr) == a) return w1_data;
    if (w0_en && int'(w0_addr) == a) return w0_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(int a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !written_now(a);
  endfunction

  task automatic idle_inputs();
    w0_en = 0; w1_en = 0; iss_en = 0; sb_flush = 0;
    w0_addr = '0; w1_addr = '0; iss_addr = '0;
    w0_data = '0; w1_data = '0;
  endtask

  // Apply the current inputs for one clock edge and advance the model accordingly.
  task automatic tick();
    bit was_written [DEPTH];
    for (int i = 0; i < DEPTH; i++) was_written[i] = written_now(i);
    if (w0_en && w0_addr != 0) m_regs[w0_addr] = w0_data;
    if (w1_en && w1_addr != 0) m_regs[w1_addr] = w1_data;
    for (int i = 1; i < DEPTH; i++) begin
      if (sb_flush || was_written[i]) m_busy[i] = 1'b0;
    end
    if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    for (int a = 0; a < DEPTH; a += 2) begin
      rd_addr = {AW'(a + 1), AW'(a)};
      #1;
      for (int k = 0; k < NR; k++) begin
        exp = (a + k == 28) ? GP_VAL : (a + k == 29) ? SP_VAL : 32'h0;
        checks++;
        if (rd_data[k*DW +: DW] !== exp) begin
          errors++;
          $display("FAIL reset_read r%0d got %h expected %h", a + k, rd_data[k*DW +: DW], exp);
        end
      end
    end
    checks++;
    if (busy_vec !== 32'h0) begin
      errors++;
      $display("FAIL reset_busy_vec got %h expected 0", busy_vec);
    end
    checks++;
    if (rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL reset_rd_busy got %b expected 00", rd_busy);
    end
    $display("reset: checked all %0d registers and busy_vec", DEPTH);
  endtask

  task automatic test_r0_write();
    idle_inputs();
    w0_en = 1; w0_addr = 0; w0_data = 32'hDEADBEEF;
    iss_en = 1; iss_addr = 0;
    rd_addr = {AW'(0), AW'(0)};
    #1;
    checks++;
    if (rd_data[DW-1:0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL r0_same_cycle got data %h busy %b expected 0 0", rd_data[DW-1:0], rd_busy[0]);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rd_data[DW-1:0] !== 32'h0 || rd_busy[0] !== 1'b0 || busy_vec[0] !== 1'b0) begin
      errors++;
      $display("FAIL r0_after got data %h busy %b bv0 %b expected 0 0 0",
               rd_data[DW-1:0], rd_busy[0], busy_vec[0]);
    end
    $display("r0_write: data %h busy %b", rd_data[DW-1:0], rd_busy[0]);
  endtask

  task automatic test_collision();
    idle_inputs();
    w0_en = 1; w0_addr = 5; w0_data = 32'h11111111;
    w1_en = 1; w1_addr = 5; w1_data = 32'h22222222;
    rd_addr = {AW'(5), AW'(5)};
    #1;
    checks++;
    if (rd_data[DW-1:0] !== 32'h22222222) begin
      errors++;
      $display("FAIL collision_bypass got %h expected 22222222", rd_data[DW-1:0]);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (rd_data[2*DW-1:DW] !== 32'h22222222) begin
      errors++;
      $display("FAIL collision_stored got %h expected 22222222", rd_data[2*DW-1:DW]);
    end
    $display("collision: r5 = %h", rd_data[2*DW-1:DW]);
  endtask

  task automatic test_issue_writeback();
    idle_inputs();
    iss_en = 1; iss_addr = 7;
    tick();
    idle_inputs();
    rd_addr = {AW'(0), AW'(7)};
    #1;
    checks++;
    if (busy_vec[7] !== 1'b1 || rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL issue_busy got bv7 %b rd_busy %b expected 1 1", busy_vec[7], rd_busy[0]);
    end
    w0_en = 1; w0_addr = 7; w0_data = 32'h0000ABCD;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[DW-1:0] !== 32'h0000ABCD) begin
      errors++;
      $display("FAIL writeback_bypass got busy %b data %h expected 0 0000abcd",
               rd_busy[0], rd_data[DW-1:0]);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (busy_vec[7] !== 1'b0 || rd_data[DW-1:0] !== 32'h0000ABCD) begin
      errors++;
      $display("FAIL writeback_after got bv7 %b data %h expected 0 0000abcd",
               busy_vec[7], rd_data[DW-1:0]);
    end
    $display("issue_writeback: r7 = %h busy %b", rd_data[DW-1:0], busy_vec[7]);
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    iss_en = 1; iss_addr = 9;
    tick();
    w1_en = 1; w1_addr = 9; w1_data = 32'h99;
    tick();
    idle_inputs();
    checks++;
    if (busy_vec[9] !== 1'b1) begin
      errors++;
      $display("FAIL issue_vs_writeback got bv9 %b expected 1", busy_vec[9]);
    end
    iss_en = 1; iss_addr = 4;
    tick();
    iss_addr = 6;
    tick();
    sb_flush = 1; iss_addr = 3;
    tick();
    idle_inputs();
    checks++;
    if (busy_vec !== 32'h0000_0008) begin
      errors++;
      $display("FAIL flush_with_issue got %h expected 00000008", busy_vec);
    end
    $display("simultaneous: busy_vec %h", busy_vec);
  endtask

  task automatic test_random();
    int a;
    logic [31:0] exp_bv;
    for (int n = 0; n < 400; n++) begin
      // Narrow address range most of the time so collisions and hazards are frequent.
      w0_en = ($urandom_range(0, 1) == 1);
      w1_en = ($urandom_range(0, 2) == 0);
      iss_en = ($urandom_range(0, 1) == 1);
      sb_flush = ($urandom_range(0, 19) == 0);
      w0_addr = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
      w1_addr = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
      iss_addr = AW'($urandom_range(0, 7));
      w0_data = $urandom;
      w1_data = $urandom;
      rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 31))};
      #1;
      for (int k = 0; k < NR; k++) begin
        a = int'(rd_addr[k*AW +: AW]);
        checks++;
        if (rd_data[k*DW +: DW] !== exp_read(a) || rd_busy[k] !== exp_busy(a)) begin
          errors++;
          $display("FAIL random_read n%0d port%0d r%0d got %h/%b expected %h/%b", n, k, a,
                   rd_data[k*DW +: DW], rd_busy[k], exp_read(a), exp_busy(a));
        end
      end
      exp_bv = model_busy_vec();
      checks++;
      if (busy_vec !== exp_bv) begin
        errors++;
        $display("FAIL random_busy_vec n%0d got %h expected %h", n, busy_vec, exp_bv);
      end
      tick();
    end
    idle_inputs();
    $display("random: 400 cycles, busy_vec %h", busy_vec);
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    w0_en = 1; w0_addr = 10; w0_data = 32'h55;
    sb_flush = 1; iss_en = 1; iss_addr = 9;
    tick();
    idle_inputs();
    iss_en = 1; iss_addr = 10;
    tick();
    idle_inputs();
    checks++;
    if (busy_vec !== 32'h0000_0600) begin
      errors++;
      $display("FAIL mid_reset_setup got %h expected 00000600", busy_vec);
    end
    w0_en = 1; w0_addr = 10; w0_data = 32'h77;
    iss_en = 1; iss_addr = 11;
    rst = 1;
    #1;
    checks++;
    if (busy_vec !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_busy_now got %h expected 0", busy_vec);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    rd_addr = {AW'(28), AW'(10)};
    #1;
    checks++;
    if (rd_data[DW-1:0] !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_r10_during got %h expected 0", rd_data[DW-1:0]);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    @(posedge clk);
    #1;
    checks++;
    if (rd_data[DW-1:0] !== 32'h0 || busy_vec !== 32'h0 || rd_data[2*DW-1:DW] !== GP_VAL) begin
      errors++;
      $display("FAIL mid_reset_after got r10 %h bv %h r28 %h expected 0 0 %h",
               rd_data[DW-1:0], busy_vec, rd_data[2*DW-1:DW], GP_VAL);
    end
    $display("mid_reset: r10 %h busy_vec %h", rd_data[DW-1:0], busy_vec);
  endtask

  initial begin
    rst = 1;
    rd_addr = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_r0_write();
    test_collision();
    test_issue_writeback();
    test_simultaneous();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file with integrated write-back scoreboard, for the pipelined core's decode/write-back stages.
- Provides NUM_RD combinational read ports, two write ports (ALU and load/MEM write-back), optional write-to-read bypass, hardwired zero register, and programmable gp/sp reset values.
- A per-register busy bitmap is set at issue and cleared at write-back, so decode can detect RAW hazards without a separate hazard table.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W.
- NUM_RD, 2, number of read ports.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads; 0 = reads see the stored value only.
- GP_IDX, 28, index of the global pointer register.
- GP_INIT, 32'h0000_1800, reset value of GP_IDX.
- SP_IDX, 29, index of the stack pointer register.
- SP_INIT, 32'h0000_2ffc, reset value of SP_IDX.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  NUM_RD*ADDR_W  read indices; port k uses slice [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port k uses slice [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  port k's register has an outstanding producer.
- w0_en  in  1  write port 0 enable (ALU write-back).
- w0_addr  in  ADDR_W  write port 0 index.
- w0_data  in  DATA_W  write port 0 data.
- w1_en  in  1  write port 1 enable (MEM write-back; higher priority than port 0).
- w1_addr  in  ADDR_W  write port 1 index.
- w1_data  in  DATA_W  write port 1 data.
- iss_en  in  1  an instruction with destination iss_addr issues this cycle.
- iss_addr  in  ADDR_W  destination register of the issuing instruction.
- sb_flush  in  1  clear all busy bits (pipeline flush).
- busy_vec  out  DEPTH  full scoreboard bitmap, registered.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - All registers cleared to 0, except GP_IDX = GP_INIT and SP_IDX = SP_INIT.
  - busy_vec = 0.
  - rd_data and rd_busy follow combinationally from the reset state.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes to and issues of index 0 are ignored.
- Writes (rising edge of clk):
  - When wN_en and wN_addr != 0, wN_data is stored.
  - If both ports target the same nonzero index, w1_data is stored.
- Reads are combinational, 0-cycle latency, per port k:
  - If rd_addr_k == 0: rd_data_k = 0.
  - Else if BYPASS and w1_en and w1_addr == rd_addr_k: w1_data.
  - Else if BYPASS and w0_en and w0_addr == rd_addr_k: w0_data.
  - Else the stored value.
  - With BYPASS = 0, reads return the stored value only, and new data is visible the cycle after the write.
- Scoreboard update, per register i != 0, at the clock edge:
  - busy_next[i] = (sb_flush ? 0 : busy[i] & ~clr[i]) | set[i].
  - clr[i] = (w0_en & w0_addr == i) | (w1_en & w1_addr == i).
  - set[i] = iss_en & iss_addr == i.
  - Issue and write-back to the same register in the same cycle: issue wins, busy stays 1 (the new producer is outstanding).
  - Flush and issue in the same cycle: busy_vec ends with only the issued bit set.
  - busy[0] is held at 0.
- rd_busy_k:
  - BYPASS = 1: busy[rd_addr_k] & ~clr[rd_addr_k]. A same-cycle write-back both forwards the data and clears the hazard.
  - BYPASS = 0: busy[rd_addr_k].
  - rd_addr_k == 0 always gives 0.
- A write to a register that is not busy is legal: the data is stored and busy is unaffected.
- Reset asserted mid-operation discards any pending writes, issues and busy bits on the same cycle.

Test Plan:
- Reset check: assert rst, then release → every rd_addr reads 0, except index 28 = 0x00001800 and index 29 = 0x00002ffc; busy_vec = 0.
- r0 write: w0 writes 0xDEADBEEF to r0, then read r0 → rd_data = 0 and rd_busy = 0, including with BYPASS = 1 in the same cycle.
- Dual-write collision: w0 writes r5 = 0x11111111 and w1 writes r5 = 0x22222222 in the same cycle → next cycle r5 reads 0x22222222. Same-cycle read with BYPASS = 1 → 0x22222222.
- Issue then write-back: iss r7 → busy_vec[7] = 1 next cycle and rd_busy = 1 for r7. Later w0 writes r7 = 0xABCD → same-cycle rd_busy = 0 with rd_data = 0xABCD (BYPASS = 1); busy_vec[7] = 0 after the edge.
- Simultaneous events:
  - iss r9 together with w1 writing r9 (r9 previously busy) → busy_vec[9] stays 1.
  - sb_flush with iss r3 while r4 and r6 are busy → busy_vec = only bit 3 set.
- Mid-operation reset: with r10 = 0x55 and busy_vec = 0x0000_0600, assert rst while w0 writes r10 = 0x77 → r10 = 0 and busy_vec = 0 immediately and after release.
